// File: rtl/memcpy_engine.sv
// Multi-cycle memcpy responder: copies len_words words from src to dst through the
// data-memory port, stalling the pipeline until the copy finishes and pulsing done.
module memcpy_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [LEN_W-1:0]  words_copied
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  words_copied_q, words_copied_d;

    logic [ADDR_W-1:0] addr_c;
    logic              we_c;
    logic [DATA_W-1:0] wdata_c;
    logic              busy_c;
    logic              stall_c;
    logic              done_c;

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        src_ptr_d      = src_ptr_q;
        dst_ptr_d      = dst_ptr_q;
        cnt_d          = cnt_q;
        words_copied_d = words_copied_q;
        addr_c         = '0;
        we_c           = 1'b0;
        wdata_c        = '0;
        busy_c         = 1'b0;
        stall_c        = 1'b0;
        done_c         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall_c        = 1'b1;
                    src_ptr_d      = {src_addr[ADDR_W-1:2], 2'b00};
                    dst_ptr_d      = {dst_addr[ADDR_W-1:2], 2'b00};
                    cnt_d          = len_words;
                    words_copied_d = '0;
                    state_d        = (len_words == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                addr_c  = src_ptr_q;
                busy_c  = 1'b1;
                stall_c = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                addr_c         = dst_ptr_q;
                we_c           = 1'b1;
                wdata_c        = mem_rdata;
                busy_c         = 1'b1;
                stall_c        = 1'b1;
                src_ptr_d      = src_ptr_q + ADDR_W'(4);
                dst_ptr_d      = dst_ptr_q + ADDR_W'(4);
                cnt_d          = cnt_q - LEN_W'(1);
                words_copied_d = words_copied_q + LEN_W'(1);
                // Comparing before the decrement keeps cnt from ever wrapping below zero.
                state_d        = (cnt_q <= LEN_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted so an aborted copy issues no write.
    always_comb begin
        mem_addr  = addr_c;
        mem_we    = we_c;
        mem_wdata = wdata_c;
        busy      = busy_c;
        stall     = stall_c;
        done      = done_c;
        if (!reset) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
            busy      = 1'b0;
            stall     = 1'b0;
            done      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the
    // clock edge, so it belongs inside the clocked block rather than its sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            src_ptr_q      <= '0;
            dst_ptr_q      <= '0;
            cnt_q          <= '0;
            words_copied_q <= '0;
        end else begin
            state_q        <= state_d;
            src_ptr_q      <= src_ptr_d;
            dst_ptr_q      <= dst_ptr_d;
            cnt_q          <= cnt_d;
            words_copied_q <= words_copied_d;
        end
    end

    assign words_copied = words_copied_q;

endmodule

// File: tb/tb_memcpy_engine.sv
// Randomised bench for memcpy_engine: a transaction-level copy model predicts every
// output cycle, plus directed cases with literal expectations.
module tb_memcpy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len_words;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy, stall, done;
    logic [15:0] words_copied;

    memcpy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len_words    (len_words),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .stall        (stall),
        .done         (done),
        .words_copied (words_copied)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        busy;
        logic        stall;
        logic        done;
        logic [15:0] wc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    logic [15:0] model_wc = '0;
    bit          chk_en   = 1'b0;
    int          vectors     = 0;
    int          miscompares = 0;

    int          stall_cnt, done_cnt, we_cnt;
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];

    function automatic logic [31:0] init_val(logic [29:0] w);
        return {w, 2'b00} * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return init_val(a[31:2]);
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return init_val(a[31:2]);
    endfunction

    task automatic wr_both(input logic [31:0] a, input logic [31:0] v);
        mem[a[31:2]]     = v;
        ref_mem[a[31:2]] = v;
    endtask

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Data memory with one-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[31:2]] = mem_wdata;
        mem_rdata <= mem_rd(mem_addr);
    end

    always @(negedge clk) begin
        if (stall) stall_cnt++;
        if (done) done_cnt++;
        if (mem_we) begin
            we_cnt++;
            wr_log.push_back(mem_addr);
        end
        if (busy && !mem_we) rd_log.push_back(mem_addr);
    end

    // Per-cycle comparison against the predicted trace; idle when nothing is queued.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{32'h0, 1'b0, 32'h0, 1'b0, start, 1'b0, model_wc};
            check($sformatf("cycle@%0t {addr,we,wdata,busy,stall,done,wc}", $time),
                  {mem_addr, mem_we, mem_wdata, busy, stall, done, words_copied},
                  {e.addr, e.we, e.wdata, e.busy, e.stall, e.done, e.wc});
        end
    end

    task automatic clear_logs();
        stall_cnt = 0;
        done_cnt  = 0;
        we_cnt    = 0;
        rd_log.delete();
        wr_log.delete();
    endtask

    // Called just after a rising edge with the engine idle; returns just after the
    // edge that ends the done cycle. keep leaves start asserted for a back-to-back request.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input bit keep);
        logic [31:0] a_s, a_d, sa, da, v;
        a_s = {src[31:2], 2'b00};
        a_d = {dst[31:2], 2'b00};
        exp_q.push_back('{32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, model_wc});
        for (int i = 0; i < int'(len); i++) begin
            sa = a_s + 32'(4 * i);
            da = a_d + 32'(4 * i);
            v  = ref_rd(sa);
            ref_mem[da[31:2]] = v;
            exp_q.push_back('{sa, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 16'(i)});
            exp_q.push_back('{da, 1'b1, v, 1'b1, 1'b1, 1'b0, 16'(i)});
        end
        exp_q.push_back('{32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, len});
        model_wc = len;

        start     = 1'b1;
        src_addr  = src;
        dst_addr  = dst;
        len_words = len;
        @(posedge clk); #1;
        for (int i = 0; i < 2 * int'(len); i++) begin
            start     = 1'($urandom_range(0, 1));
            src_addr  = $urandom;
            dst_addr  = $urandom;
            len_words = 16'($urandom);
            @(posedge clk); #1;
        end
        start = keep;
        @(posedge clk); #1;
        start = keep;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] s, d;
        logic [15:0] n;

        reset     = 1'b0;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len_words = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", {mem_addr, mem_we, mem_wdata, busy, stall, done, words_copied},
              96'h0);
        @(posedge clk); #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Basic copy
        wr_both(32'h100, 32'd11);
        wr_both(32'h104, 32'd22);
        wr_both(32'h108, 32'd33);
        wr_both(32'h10C, 32'd44);
        clear_logs();
        run_copy(32'h100, 32'h200, 16'd4, 1'b0);
        check("basic_stall_cycles", 96'(stall_cnt), 96'd9);
        check("basic_done_pulses", 96'(done_cnt), 96'd1);
        check("basic_writes", 96'(we_cnt), 96'd4);
        check("basic_wr_addrs", {wr_log[0], wr_log[1], wr_log[2]}, {32'h200, 32'h204, 32'h208});
        check("basic_wr_last", 96'(wr_log[3]), 96'h20C);
        check("basic_data", {mem_rd(32'h200), mem_rd(32'h204), mem_rd(32'h208)},
              {32'd11, 32'd22, 32'd33});
        check("basic_data_last", 96'(mem_rd(32'h20C)), 96'd44);
        check("basic_wc", 96'(words_copied), 96'd4);

        // Zero length
        clear_logs();
        run_copy(32'h300, 32'h400, 16'd0, 1'b0);
        check("zero_stall_cycles", 96'(stall_cnt), 96'd1);
        check("zero_writes", 96'(we_cnt), 96'd0);
        check("zero_done", 96'(done_cnt), 96'd1);
        check("zero_wc", 96'(words_copied), 96'd0);

        // Misaligned pointers with address wrap
        clear_logs();
        run_copy(32'hFFFF_FFFE, 32'h0000_0013, 16'd2, 1'b0);
        check("wrap_reads", {32'(rd_log.size()), rd_log[0], rd_log[1]},
              {32'd2, 32'hFFFF_FFFC, 32'h0000_0000});
        check("wrap_writes", {32'(wr_log.size()), wr_log[0], wr_log[1]},
              {32'd2, 32'h0000_0010, 32'h0000_0014});

        // Forward overlap propagates the first word
        wr_both(32'h0, 32'hA);
        wr_both(32'h4, 32'hB);
        wr_both(32'h8, 32'hC);
        wr_both(32'hC, 32'hD);
        run_copy(32'h0, 32'h4, 16'd3, 1'b0);
        check("overlap_data", {mem_rd(32'h4), mem_rd(32'h8), mem_rd(32'hC)},
              {32'hA, 32'hA, 32'hA});

        // Back-to-back with start held through the first copy
        clear_logs();
        run_copy(32'h500, 32'h600, 16'd1, 1'b1);
        run_copy(32'h700, 32'h800, 16'd1, 1'b0);
        check("b2b_done_pulses", 96'(done_cnt), 96'd2);
        check("b2b_writes", {32'(we_cnt), wr_log[0], wr_log[1]}, {32'd2, 32'h600, 32'h800});

        // Randomised copies, some near the top of the address space and overlapping
        for (int t = 0; t < 40; t++) begin
            s = $urandom;
            if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            d = ($urandom_range(0, 1) == 1) ? s + 32'($urandom_range(0, 16)) : $urandom;
            n = 16'($urandom_range(0, 12));
            run_copy(s, d, n, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset during the third write aborts the copy
        chk_en = 1'b0;
        for (int i = 0; i < 8; i++) wr_both(32'h1000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
        clear_logs();
        start     = 1'b1;
        src_addr  = 32'h1000;
        dst_addr  = 32'h2000;
        len_words = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", {mem_addr, mem_we, mem_wdata, busy, stall, done, words_copied},
              96'h0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_write_count", 96'((we_cnt == 2) || (we_cnt == 3)), 96'd1);
        check("abort_kept_words", {mem_rd(32'h2000), mem_rd(32'h2004)},
              {32'hC0DE_0000, 32'hC0DE_0001});
        check("abort_untouched", 96'(mem_rd(32'h200C)), 96'(init_val(30'h0000_0803)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
